// File: rtl/shared_memory_arbiter.sv
// shared_memory_arbiter
//   Arbitrates NREQ requesters onto one shared BRAM port. Grants are
//   round-robin. A requester can also take a locked burst tenure, which
//   holds the port for up to MAX_BURST handshakes. Read data comes back on
//   a shared bus, tagged by a one-hot rd_valid strobe for the requester.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   RD_LATENCY  BRAM cycles from mem_en (read) to valid mem_dout
//   MAX_BURST   maximum handshakes per locked tenure (1..255)
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   req_valid/req_lock      per-requester request / lock request
//   req_we/addr/wdata       per-requester byte enables, address, write data
//   req_ready               one-hot grant (combinational)
//   rd_valid, rd_data       read-return strobe (one-hot) and shared data
//   mem_en/we/addr/din      registered BRAM command
//   mem_dout                BRAM read data
//   locked                  high while a locked tenure is active
module shared_memory_arbiter #(
  parameter int NREQ       = 4,
  parameter int RD_LATENCY = 2,
  parameter int MAX_BURST  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [4*NREQ-1:0]    req_we,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rd_valid,
  output logic [31:0]          rd_data,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout,
  output logic                 locked
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   w_last_grant_nxt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_nxt;
  logic [7:0]      r_burst_cnt;
  logic [7:0]      w_burst_nxt;
  logic [7:0]      w_burst_inc;

  logic            w_rr_found;
  logic [IW-1:0]   w_rr_idx;
  logic            w_grant_vld;
  logic [IW-1:0]   w_grant_idx;
  logic            w_hs;
  logic [NREQ-1:0] w_ready;
  logic [3:0]      w_sel_we;
  logic [31:0]     w_sel_addr;
  logic [31:0]     w_sel_wdata;

  logic            r_mem_en;
  logic [3:0]      r_mem_we;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_din;

  logic [RD_LATENCY:0] r_tag_vld;
  logic [IW-1:0]       r_tag_idx [RD_LATENCY+1];
  logic [NREQ-1:0]     w_rd_onehot;
  logic [NREQ-1:0]     r_rd_valid;
  logic [31:0]         r_rd_data;

  // Round-robin search: first valid requester after r_last_grant, wrapping.
  always_comb begin
    int v_s;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    v_s        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      v_s = int'(r_last_grant) + k;
      if (v_s >= NREQ) v_s = v_s - NREQ;
      if (!w_rr_found && req_valid[v_s[IW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_s[IW-1:0];
      end
    end
  end

  // While locked only the owner can win; the port idles if it is not valid.
  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_grant_vld = req_valid[r_owner];
      w_grant_idx = r_owner;
    end else begin
      w_grant_vld = w_rr_found;
      w_grant_idx = w_rr_idx;
    end
  end

  assign w_hs = w_grant_vld & reset_n;

  // Decode the grant into a one-hot ready and mux the winner's command.
  always_comb begin
    w_ready     = '0;
    w_sel_we    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IW'(i)) begin
        w_ready[i]  = w_hs;
        w_sel_we    = req_we[i*4 +: 4];
        w_sel_addr  = req_addr[i*32 +: 32];
        w_sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  assign req_ready = w_ready;

  // FSM next state. A lock release and an owner handshake in the same cycle
  // both take effect: the transfer is issued and the FSM returns to ARB.
  assign w_burst_inc = r_burst_cnt + 8'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_owner_nxt      = r_owner;
    w_burst_nxt      = r_burst_cnt;
    case (r_state)
      ST_ARB: begin
        if (w_hs) begin
          w_last_grant_nxt = w_grant_idx;
          // A one-handshake tenure is complete on entry, so never lock.
          if (req_lock[w_grant_idx] && (MAX_BURST > 1)) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_grant_idx;
            w_burst_nxt = 8'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (w_hs) w_burst_nxt = w_burst_inc;
        if ((w_hs && (w_burst_inc == BURST_LIMIT)) || !req_lock[r_owner]) begin
          w_state_nxt      = ST_ARB;
          // Owner becomes lowest priority for the next round.
          w_last_grant_nxt = r_owner;
          w_burst_nxt      = 8'd0;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_ARB;
      r_last_grant <= IW'(NREQ-1);
      r_owner      <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

  assign locked = (r_state == ST_LOCKED);

  // Registered BRAM command; address/data hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_mem_en <= w_hs;
      r_mem_we <= w_hs ? w_sel_we : 4'b0;
      if (w_hs) begin
        r_mem_addr <= w_sel_addr;
        r_mem_din  <= w_sel_wdata;
      end
    end
  end

  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

  // Read tag pipeline: stage k is aligned with the access k cycles after
  // mem_en, so the last stage lines up with valid mem_dout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      for (int k = 0; k <= RD_LATENCY; k++) r_tag_idx[k] <= '0;
    end else begin
      r_tag_vld[0] <= w_hs && (w_sel_we == 4'b0);
      r_tag_idx[0] <= w_grant_idx;
      for (int k = 1; k <= RD_LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  always_comb begin
    w_rd_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_tag_idx[RD_LATENCY] == IW'(i)) w_rd_onehot[i] = 1'b1;
    end
  end

  // Read return; rd_data keeps its last value between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else begin
      if (r_tag_vld[RD_LATENCY]) begin
        r_rd_valid <= w_rd_onehot;
        r_rd_data  <= mem_dout;
      end else begin
        r_rd_valid <= '0;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_shared_memory_arbiter.sv
module tb_shared_memory_arbiter;

  localparam int NREQ = 4;
  localparam int RL   = 2;
  localparam int MB   = 16;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_lock;
  logic [4*NREQ-1:0]   req_we;
  logic [32*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rd_valid;
  logic [31:0]         rd_data;
  logic                mem_en;
  logic [3:0]          mem_we;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_din;
  logic [31:0]         mem_dout;
  logic                locked;

  always #5 clk = ~clk;

  shared_memory_arbiter #(.NREQ(NREQ), .RD_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .locked(locked)
  );

  // BRAM stand-in: data returned RL cycles after mem_en is a fixed function
  // of the address; cycles without an access return junk.
  function automatic logic [31:0] bram_f(input logic [31:0] a);
    return 32'hCAFE0000 ^ a;
  endfunction

  logic [31:0] bram_pipe [RL];
  always @(posedge clk) begin
    for (int k = RL-1; k >= 1; k--) bram_pipe[k] <= bram_pipe[k-1];
    bram_pipe[0] <= mem_en ? bram_f(mem_addr) : (32'h5A5A0000 | 32'($urandom_range(0, 65535)));
  end
  assign mem_dout = bram_pipe[RL-1];

  // Reference model state
  int  m_lg, m_own, m_cnt;
  bit  m_lk;
  int  cyc;
  typedef struct { int due; int idx; logic [31:0] data; } rd_t;
  rd_t rdq[$];
  logic            e_en;
  logic [3:0]      e_we;
  logic [31:0]     e_addr, e_din, e_rdd;
  logic [NREQ-1:0] e_rdv;
  logic [NREQ-1:0] obs_rdy, obs_rdv;
  logic [31:0]     obs_rdd;

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int model_grant();
    int i;
    if (m_lk) return req_valid[m_own] ? m_own : -1;
    for (int k = 1; k <= NREQ; k++) begin
      i = (m_lg + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic void set_req(input int i, input bit v, input bit l,
                                  input logic [3:0] we, input logic [31:0] a,
                                  input logic [31:0] d);
    req_valid[i]         = v;
    req_lock[i]          = l;
    req_we[4*i +: 4]     = we;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
  endfunction

  function automatic void clear_reqs();
    req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endfunction

  // One clock cycle: check grant mid-cycle, advance model, check registered
  // outputs just after the edge.
  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("locked", 32'(locked), 32'(m_lk));
    e_en = (g >= 0);
    e_we = 4'h0;
    if (g >= 0) begin
      e_we   = req_we[4*g +: 4];
      e_addr = req_addr[32*g +: 32];
      e_din  = req_wdata[32*g +: 32];
      if (e_we == 4'h0) rdq.push_back('{cyc + 2 + RL, g, bram_f(e_addr)});
    end
    if (!m_lk) begin
      if (g >= 0) begin
        m_lg = g;
        if (req_lock[g] && MB > 1) begin m_lk = 1; m_own = g; m_cnt = 1; end
      end
    end else begin
      if (g >= 0) m_cnt++;
      if ((g >= 0 && m_cnt == MB) || !req_lock[m_own]) begin
        m_lk = 0; m_lg = m_own; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_din", mem_din, e_din);
    end
    e_rdv = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      e_rdv[rdq[0].idx] = 1'b1;
      e_rdd = rdq[0].data;
      void'(rdq.pop_front());
    end
    obs_rdv = rd_valid;
    obs_rdd = rd_data;
    chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
    chk("rd_data", rd_data, e_rdd);
  endtask

  // Assert reset with every requester valid; all outputs must read zero.
  task automatic reset_phase(input int hold);
    reset_n   = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
    end
    m_lg = NREQ - 1; m_lk = 0; m_own = 0; m_cnt = 0;
    rdq.delete();
    e_rdd = 32'h0;
    reset_n = 1'b1;
  endtask

  initial begin
    int n2;
    n_vec = 0; n_err = 0; cyc = 0;
    clear_reqs();
    reset_n = 1'b0;
    reset_phase(2);

    // Round robin with all requesters valid, no lock.
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 4'hF, 32'h1000 + 32'(i), 32'h100 * 32'(i));
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_grant", 32'(obs_rdy), 32'(1 << (k % NREQ)));
    end

    // Single read from requester 1.
    clear_reqs();
    set_req(1, 1, 0, 4'h0, 32'h10, 32'h0);
    tick();
    clear_reqs();
    for (int j = 2; j <= 5; j++) begin
      tick();
      if (j == 4) begin
        chk("rd1_valid", 32'(obs_rdv), 32'h2);
        chk("rd1_data", obs_rdd, 32'hCAFE0010);
      end else begin
        chk("rd1_quiet", 32'(obs_rdv), 32'h0);
      end
    end

    // Locked write burst from requester 2 with requester 0 waiting.
    clear_reqs();
    set_req(2, 1, 1, 4'hF, 32'h2000, 32'hA5A5_0002);
    n2 = 0;
    tick();
    if (obs_rdy == 4'b0100) n2++;
    set_req(0, 1, 0, 4'h3, 32'h3000, 32'h1234_5678);
    for (int k = 1; k < MB; k++) begin
      tick();
      if (obs_rdy == 4'b0100) n2++;
    end
    tick();
    chk("burst_len", 32'(n2), 32'(MB));
    chk("after_burst", 32'(obs_rdy), 32'h1);
    clear_reqs();
    tick();

    // Requester 3 locks, releases after 3 handshakes; requester 1 waits.
    set_req(3, 1, 1, 4'hF, 32'h4000, 32'h0000_0003);
    tick();
    set_req(1, 1, 0, 4'hF, 32'h5000, 32'h0000_0001);
    tick();
    tick();
    set_req(3, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("release_idle", 32'(obs_rdy), 32'h0);
    tick();
    chk("release_next", 32'(obs_rdy), 32'h2);
    clear_reqs();

    // Interleaved reads from requesters 0 and 2.
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1, 0, 4'h0, 32'h100 + 32'(4*k), 32'h0);
      set_req(2, 1, 0, 4'h0, 32'h200 + 32'(4*k), 32'h0);
      tick();
    end
    clear_reqs();
    repeat (RL + 3) tick();

    // Reset one cycle after a read handshake.
    set_req(0, 1, 0, 4'h0, 32'h40, 32'h0);
    tick();
    clear_reqs();
    reset_phase(RL + 3);
    req_valid = '1;
    tick();
    chk("post_rst_grant", 32'(obs_rdy), 32'h1);
    clear_reqs();
    repeat (RL + 3) tick();

    // Randomized traffic with sticky lock requests.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) req_lock[i] = ~req_lock[i];
        req_we[4*i +: 4]      = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        req_addr[32*i +: 32]  = $urandom;
        req_wdata[32*i +: 32] = $urandom;
      end
      tick();
    end
    clear_reqs();
    repeat (RL + 4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_memory_arbiter.md
SHARED_MEMORY_ARBITER -- requirements
Module: shared_memory_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter RD_LATENCY, default 2, BRAM cycles from mem_en (we=0) to valid mem_dout.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum handshakes per locked tenure (1..255).
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous assertion, active-low; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have port req_valid  in  NREQ  request pending, per requester.
REQ-007 SHALL have port req_lock  in  NREQ  request exclusive burst tenure.
REQ-008 SHALL have port req_we  in  4*NREQ  byte write enables; all zero = read.
REQ-009 SHALL have port req_addr  in  32*NREQ  byte address.
REQ-010 SHALL have port req_wdata  in  32*NREQ  write data.
REQ-011 SHALL have port req_ready  out  NREQ  one-hot grant; transfer when valid&ready.
REQ-012 SHALL have port rd_valid  out  NREQ  one-cycle read-return strobe.
REQ-013 SHALL have port rd_data  out  32  read-return data, shared.
REQ-014 SHALL have ports mem_en out 1, mem_we out 4, mem_addr out 32, mem_din out 32, mem_dout in 32  shared PS BRAM port.
REQ-015 SHALL have port locked  out  1  high while in LOCKED state.

Function
REQ-016 SHALL be combinational in req_ready: at most one bit high per cycle, only for a requester with req_valid high.
REQ-017 SHALL implement states ARB and LOCKED.
REQ-018 In ARB: grant the first valid requester searching from (last_grant+1) mod NREQ upward with wrap; update last_grant on each handshake.
REQ-019 ARB->LOCKED when the handshake requester has req_lock high; owner = that index, burst_cnt = 1.
REQ-020 In LOCKED: only owner may be granted; others see req_ready=0; bus idles if owner not valid.
REQ-021 In LOCKED: each owner handshake increments burst_cnt (8-bit).
REQ-022 LOCKED->ARB when req_lock[owner] is low in any cycle, or on the handshake that makes burst_cnt = MAX_BURST; last_grant = owner so owner is lowest priority next.
REQ-023 Lock release and owner handshake in the same cycle: handshake completes, then ARB.
REQ-024 Handshake in cycle T SHALL drive registered mem_en=1, mem_we, mem_addr, mem_din in T+1; mem_en=0 and mem_we=0 in cycles without handshake; back-to-back handshakes give one access per cycle.
REQ-025 SHALL track read ownership in a RD_LATENCY+1 deep tag pipeline (valid bit + index).
REQ-026 Read handshake at T SHALL give rd_valid[index]=1 and rd_data=mem_dout (registered) in T+2+RD_LATENCY, exactly one cycle.
REQ-027 Writes SHALL produce no rd_valid.
REQ-028 Reads and writes SHALL issue in handshake order; no reordering; no read/write hazard logic (BRAM semantics apply).
REQ-029 rd_data SHALL hold its last value when rd_valid is all zero.
REQ-030 Address and data SHALL pass unmodified (no width conversion, no alignment checks).

Reset
REQ-031 While reset_n=0: state=ARB, last_grant=NREQ-1 (requester 0 highest priority first), burst_cnt=0, tag pipeline cleared.
REQ-032 While reset_n=0: mem_en=0, mem_we=0, mem_addr=0, mem_din=0, rd_valid=0, rd_data=0, locked=0; req_ready=0.
REQ-033 Reset mid-operation SHALL drop all in-flight reads; no rd_valid after reset_n deasserts for pre-reset requests.
REQ-034 Deassertion SHALL be synchronised to clk outside this block; first grant no earlier than first clk edge after deassertion.

Verification
REQ-035 All four requesters valid continuously, no lock -> grants 0,1,2,3,0,... one per cycle; mem_en high every cycle.
REQ-036 Req 1 reads 0x10 (mem returns 0xCAFE0010) at T, RD_LATENCY=2 -> rd_valid=0b0010, rd_data=0xCAFE0010 at T+4 only.
REQ-037 Req 2 locked writes, req 0 valid throughout, MAX_BURST=16 -> 16 consecutive req 2 grants, locked drops, next grant req 0.
REQ-038 Req 3 locks, drops req_lock after 3 handshakes with req 1 waiting -> LOCKED exits same cycle, req 1 granted next cycle.
REQ-039 Reads from req 0 and req 2 interleaved back-to-back -> rd_valid returns in issue order with matching data.
REQ-040 reset_n low one cycle after a read handshake -> no rd_valid emitted; outputs zero; first post-reset grant to req 0 when all valid.
